// File: rtl/sw_debounce.sv
// Per-bit 2-flop synchronizer plus stability counter; a new level is accepted after
// STABLE_CYCLES consecutive enabled cycles. Define SW_DEBOUNCE_EDGE_EN to build edge pulses.
module sw_debounce #(
   parameter int unsigned WIDTH         = 3,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned STABLE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             changed
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]            s1, s2;
   logic [WIDTH-1:0]            clean_q, clean_d;
   logic [WIDTH-1:0]            accept;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // The synchronizer runs independently of ena so it never holds a stale sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         // NOTE: non-blocking assignments make s2 take the old s1, giving a true two-stage chain.
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // State register: per-bit accepted level and stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clean_q <= '0;
         cnt_q   <= '0;
      end else begin
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a bit is PENDING while s2 differs from clean; any agreement restarts its count.
   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      accept = '0;
      cnt_d  = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (ena) begin
            if (s2[i] == clean_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
               accept[i] = 1'b1;
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      clean_d = clean_q ^ accept;
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] rise_q, fall_q;
   logic             changed_q;

   // Pulses are registered alongside clean_q so they coincide with the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         rise_q    <= accept & s2;
         fall_q    <= accept & ~s2;
         changed_q <= |accept;
      end
   end

   always_comb begin
      rise_pulse = rise_q;
      fall_pulse = fall_q;
      changed    = changed_q;
   end
`else
   always_comb begin
      rise_pulse = '0;
      fall_pulse = '0;
      changed    = 1'b0;
   end
`endif

   always_comb clean_out = clean_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (WIDTH=3, STABLE_CYCLES=4): directed table, hand-written corner
// sequences, then random stimulus against a run-length reference model.
module tb_sw_debounce;

   localparam int N = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, ena;
   logic [2:0] raw_in, clean_out, rise_pulse, fall_pulse;
   logic       changed;

   int n_pass  = 0;
   int n_total = 0;

   sw_debounce #(.WIDTH(3), .CNT_W(16), .STABLE_CYCLES(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .changed    (changed)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, required completion before 1ms");
      $fatal(1);
   end

   // Reference model: a bit adopts a new level once N consecutive enabled samples disagree with it.
   logic [2:0] m_s1, m_s2, m_clean, m_rise, m_fall;
   int         m_run [3];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         m_rise = '0;
         m_fall = '0;
         if (ena) begin
            for (int i = 0; i < 3; i++) begin
               if (m_s2[i] != m_clean[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == N) begin
                     m_clean[i] = m_s2[i];
                     if (m_s2[i]) m_rise[i] = 1'b1;
                     else         m_fall[i] = 1'b1;
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = raw_in;
      end
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got {clean,rise,fall,chg}=%b required %b", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic check_outs(input string name, input logic [2:0] c, input logic [2:0] r,
                             input logic [2:0] f, input logic ch);
      logic [9:0] exp;
      exp = {c, EDGE_EN ? r : 3'b000, EDGE_EN ? f : 3'b000, EDGE_EN ? ch : 1'b0};
      check(name, {clean_out, rise_pulse, fall_pulse, changed}, exp);
   endtask

   // Drive inputs away from the edge, clock once, advance the model, sample 1 ns later.
   task automatic tick(input logic r, input logic e, input logic [2:0] raw);
      rst_n  = r;
      ena    = e;
      raw_in = raw;
      if (!r) model_reset();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic       rst_n;
      logic       ena;
      logic [2:0] raw;
      logic [2:0] clean;
      logic [2:0] rise;
      logic [2:0] fall;
      logic       chg;
   } vec_t;

   vec_t tbl [22];

   initial begin
      logic [2:0] raw;

      rst_n  = 1'b0;
      ena    = 1'b1;
      raw_in = 3'b000;
      model_reset();

      // Reset with inputs high, then 0->1 on all bits, then fall and rise on bit1.
      tbl = '{
         '{1'b0, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b111, 3'b111, 3'b000, 1'b1},
         '{1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b101, 3'b101, 3'b000, 3'b010, 1'b1},
         '{1'b1, 1'b1, 3'b101, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 1'b0},
         '{1'b1, 1'b1, 3'b111, 3'b111, 3'b010, 3'b000, 1'b1},
         '{1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0}
      };

      for (int k = 0; k < 22; k++) begin
         tick(tbl[k].rst_n, tbl[k].ena, tbl[k].raw);
         check_outs($sformatf("table_row%0d", k), tbl[k].clean, tbl[k].rise, tbl[k].fall, tbl[k].chg);
      end

      // Bounce rejection: 3-cycle highs separated by single lows never reach acceptance.
      tick(1'b0, 1'b1, 3'b000);
      for (int rep = 0; rep < 2; rep++) begin
         for (int j = 0; j < 4; j++) begin
            tick(1'b1, 1'b1, (j < 3) ? 3'b001 : 3'b000);
            check_outs("bounce", 3'b000, 3'b000, 3'b000, 1'b0);
         end
      end
      for (int j = 0; j < 6; j++) begin
         tick(1'b1, 1'b1, 3'b000);
         check_outs("bounce_settle", 3'b000, 3'b000, 3'b000, 1'b0);
      end

      // Freeze: two counted cycles, ena low for 10, then acceptance two edges after re-enable.
      for (int j = 0; j < 4; j++) begin
         tick(1'b1, 1'b1, 3'b100);
         check_outs("freeze_pre", 3'b000, 3'b000, 3'b000, 1'b0);
      end
      for (int j = 0; j < 10; j++) begin
         tick(1'b1, 1'b0, 3'b100);
         check_outs("freeze_hold", 3'b000, 3'b000, 3'b000, 1'b0);
      end
      tick(1'b1, 1'b1, 3'b100);
      check_outs("freeze_resume1", 3'b000, 3'b000, 3'b000, 1'b0);
      tick(1'b1, 1'b1, 3'b100);
      check_outs("freeze_accept", 3'b100, 3'b100, 3'b000, 1'b1);
      tick(1'b1, 1'b1, 3'b100);
      check_outs("freeze_after", 3'b100, 3'b000, 3'b000, 1'b0);

      // Reset mid-count: bit0 pending at count 3, then async reset clears everything at once.
      for (int j = 0; j < 5; j++) begin
         tick(1'b1, 1'b1, 3'b101);
         check_outs("midrst_pend", 3'b100, 3'b000, 3'b000, 1'b0);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outs("midrst_immediate", 3'b000, 3'b000, 3'b000, 1'b0);
      tick(1'b0, 1'b1, 3'b101);
      check_outs("midrst_held", 3'b000, 3'b000, 3'b000, 1'b0);
      for (int j = 0; j < 5; j++) begin
         tick(1'b1, 1'b1, 3'b101);
         check_outs("midrst_relatency", 3'b000, 3'b000, 3'b000, 1'b0);
      end
      tick(1'b1, 1'b1, 3'b101);
      check_outs("midrst_accept", 3'b101, 3'b101, 3'b000, 1'b1);
      tick(1'b1, 1'b1, 3'b101);
      check_outs("midrst_after", 3'b101, 3'b000, 3'b000, 1'b0);

      // Random phase against the reference model.
      raw = 3'b000;
      tick(1'b0, 1'b1, raw);
      for (int c = 0; c < 2000; c++) begin
         logic r, e;
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 299) != 0);
         tick(r, e, raw);
         check_outs($sformatf("random_cycle%0d", c), m_clean, m_rise, m_fall, |(m_rise | m_fall));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage that sits directly upstream of the combinational logic block fed by the `ui_in` switch inputs. Each of WIDTH raw, asynchronous switch/pin inputs passes through a 2-flop synchronizer and a per-bit stability counter. The stage presents glitch-free levels (`clean_out`) to the downstream logic and optional one-cycle edge pulses. The downstream block consumes `clean_out[2:0]` in place of raw `ui_in[2:0]`.

## Interface
- `WIDTH`, default 3: number of independent input bits.
- `CNT_W`, default 16: width of each stability counter.
- `STABLE_CYCLES`, default 50000: consecutive cycles a new level must persist before acceptance. Legal range is 1 ≤ STABLE_CYCLES ≤ 2^CNT_W − 1; values outside this range are illegal.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: when high, counters advance and outputs may update; when low, debounce state is frozen.
- `raw_in`  in  WIDTH: raw asynchronous inputs.
- `clean_out`  out  WIDTH: debounced level per bit.
- `rise_pulse`  out  WIDTH: one-cycle high when the matching `clean_out` bit goes 0→1.
- `fall_pulse`  out  WIDTH: one-cycle high when the matching `clean_out` bit goes 1→0.
- `changed`  out  1: OR of all bits of `rise_pulse | fall_pulse`.

## Operation
- Synchronizer: two flops per bit, `s1 <= raw_in`, `s2 <= s1`. It runs regardless of `ena`. Reset value is 0.
- Per-bit state is `clean[i]` and `cnt[i]` (CNT_W bits). All bits are independent; there is no shared state except `changed`.
- Each rising edge with `ena`=1:
  - If `s2[i] == clean[i]`, then `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYCLES-1`, then `clean[i] <= s2[i]`, `cnt[i] <= 0`, and the matching edge pulse is asserted for the next cycle.
  - Else `cnt[i] <= cnt[i] + 1`.
- Any single-cycle return of `s2[i]` to the current `clean[i]` restarts that bit's count from 0. A bounce shorter than STABLE_CYCLES is never propagated.
- `ena`=0: `cnt` and `clean` hold their values, and all pulses are 0. When `ena` returns to 1, counting resumes from the held count.
- The counter never exceeds STABLE_CYCLES-1, so it does not wrap.
- Each bit has two implicit states: STABLE (`s2 == clean`) and PENDING (`s2 != clean`, counting). PENDING→STABLE occurs either on acceptance or on a level reverting.

## Timing
- Reset (async assert, synchronous-to-clk deassert expected upstream): `s1`, `s2`, `clean_out`, `cnt`, `rise_pulse`, `fall_pulse`, and `changed` are all 0 immediately.
- Reset mid-count discards any pending change. After reset, a raw input already held at 1 is accepted as a normal 0→1 edge, with full latency and a `rise_pulse`.
- Latency: raw level first sampled at edge E0. Then `s2` updates at E1, and `clean_out` updates at E(1+STABLE_CYCLES), given `ena`=1 throughout. Total latency is STABLE_CYCLES+1 edges after E0.
- `rise_pulse`/`fall_pulse`/`changed` are registered. They are high for exactly the one cycle following the edge that updates `clean_out`, and are coincident with the new `clean_out` value.
- Multiple bits accepted on the same edge assert their pulses together. `changed` is high for that single cycle.
- All outputs are driven directly from flops, with no combinational path from `raw_in`.

## Configuration
- Macro `SW_DEBOUNCE_EDGE_EN`.
- Defined: the pulse registers exist and `rise_pulse`, `fall_pulse`, and `changed` behave as specified.
- Not defined: the pulse registers are not built. `rise_pulse`, `fall_pulse`, and `changed` are tied to 0. `clean_out` behaviour is identical in both cases.

## Test plan
Benches use STABLE_CYCLES=4, WIDTH=3, and `ena`=1 unless stated otherwise.
- Reset: assert `rst_n`=0 with `raw_in`=3'b111 → all outputs are 0 during reset. After release, `clean_out`=3'b111 appears 5 edges after the first sampling edge, with `rise_pulse`=3'b111 and `changed`=1 for exactly one cycle.
- Bounce rejection: bit0 toggles 1,0,1,0 with 3-cycle highs → `clean_out[0]` stays 0, and no pulses are produced.
- Clean edge: bit1 goes 0→1 and is held → `clean_out[1]`=1 at E5 and `rise_pulse[1]` for one cycle. Then bit1 goes 1→0 and is held → `fall_pulse[1]` for one cycle, with the same latency.
- Freeze: bit2 goes high, and `ena`=0 after 2 counted cycles for 10 cycles → `clean_out[2]` stays 0 with no pulses. After `ena`=1, acceptance occurs 2 edges later.
- Reset mid-count: bit0 is pending at count 3 when `rst_n` pulses low → outputs are 0 immediately, and the full 5-edge latency is required again.
- Macro off: repeat the clean-edge test without `SW_DEBOUNCE_EDGE_EN` → `clean_out` timing is identical, and `rise_pulse`, `fall_pulse`, and `changed` stay 0 throughout.
